// File: rtl/npu_cmd_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | npu_cmd_scheduler: decodes host commands, dispatches START jobs, tracks  |
// | in-flight units, returns response words. Option: NPU_SCHED_TIMEOUT_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module npu_cmd_scheduler #(
    parameter int NUM_UNITS      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          cmd_data,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic [23:0]          unit_arg,
    input  logic [NUM_UNITS-1:0] unit_busy,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic [15:0]          resp_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 sched_idle,
    output logic                 err_sticky
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_DISPATCH  = 3'd2,
        S_WAIT_SYNC = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    localparam logic [3:0] C_OP_NOP    = 4'd0;
    localparam logic [3:0] C_OP_START  = 4'd2;
    localparam logic [3:0] C_OP_SYNC   = 4'd3;
    localparam logic [3:0] C_OP_STATUS = 4'd4;
    localparam logic [4:0] C_NUM_UNITS = 5'(NUM_UNITS);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_cmd;
    logic [NUM_UNITS-1:0] r_inflight;
    logic [3:0]           r_outstanding;
    logic [NUM_UNITS-1:0] r_unit_start;
    logic [NUM_UNITS-1:0] w_unit_start_nxt;
    logic [23:0]          r_unit_arg;
    logic [23:0]          w_unit_arg_nxt;
    logic [15:0]          r_resp_data;
    logic [15:0]          w_resp_data_nxt;
    logic                 r_err_sticky;
    logic                 w_start_fire;

    logic [3:0]           w_op;
    logic [3:0]           w_tag;
    logic [NUM_UNITS-1:0] w_unit_mask;
    logic [NUM_UNITS-1:0] w_done_valid;
    logic [3:0]           w_done_cnt;
    logic                 w_stray;
    logic                 w_timeout;

    assign w_op  = r_cmd[31:28];
    assign w_tag = r_cmd[27:24];

    // One-hot of the addressed unit; all-zero when the tag is out of range.
    always_comb begin
        w_unit_mask = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_unit_mask[i] = (w_tag == 4'(i));
        end
    end

    assign w_done_valid = unit_done & r_inflight;
    assign w_stray      = |(unit_done & ~r_inflight);

    always_comb begin
        w_done_cnt = 4'd0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_done_cnt = w_done_cnt + {3'd0, w_done_valid[i]};
        end
    end

`ifdef NPU_SCHED_TIMEOUT_EN
    localparam int C_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [C_TO_W-1:0] r_to_cnt;

    // Restarts from zero on every entry into WAIT_SYNC.
    always_ff @(posedge clk) begin
        if (rst || (r_state != S_WAIT_SYNC)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + C_TO_W'(1);
        end
    end

    assign w_timeout = (r_to_cnt == C_TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_unit_start_nxt = '0;
        w_unit_arg_nxt   = r_unit_arg;
        w_resp_data_nxt  = r_resp_data;
        w_start_fire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_op)
                    C_OP_NOP: w_state_nxt = S_IDLE;
                    C_OP_START: begin
                        if ({1'b0, w_tag} >= C_NUM_UNITS) begin
                            w_resp_data_nxt = {4'hF, w_op, 8'h01};
                            w_state_nxt     = S_RESP;
                        end else begin
                            w_state_nxt = S_DISPATCH;
                        end
                    end
                    C_OP_SYNC: w_state_nxt = S_WAIT_SYNC;
                    C_OP_STATUS: begin
                        w_resp_data_nxt = {w_op, w_tag, 8'(r_inflight)};
                        w_state_nxt     = S_RESP;
                    end
                    default: begin
                        w_resp_data_nxt = {4'hF, w_op, 8'h02};
                        w_state_nxt     = S_RESP;
                    end
                endcase
            end
            S_DISPATCH: begin
                if (((unit_busy | r_inflight) & w_unit_mask) == '0) begin
                    w_unit_start_nxt = w_unit_mask;
                    w_unit_arg_nxt   = r_cmd[23:0];
                    w_start_fire     = 1'b1;
                    w_state_nxt      = S_IDLE;
                end
            end
            S_WAIT_SYNC: begin
                if (r_outstanding == 4'd0) begin
                    w_resp_data_nxt = {C_OP_SYNC, w_tag, 8'h00};
                    w_state_nxt     = S_RESP;
                end else if (w_timeout) begin
                    w_resp_data_nxt = {4'hF, C_OP_SYNC, 8'h03};
                    w_state_nxt     = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cmd        <= '0;
            r_unit_start <= '0;
            r_unit_arg   <= '0;
            r_resp_data  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_unit_start <= w_unit_start_nxt;
            r_unit_arg   <= w_unit_arg_nxt;
            r_resp_data  <= w_resp_data_nxt;
            if ((r_state == S_IDLE) && cmd_valid) begin
                r_cmd <= cmd_data;
            end
        end
    end

    // Completions retire in every state, concurrently with a dispatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight    <= '0;
            r_outstanding <= 4'd0;
            r_err_sticky  <= 1'b0;
        end else begin
            r_inflight    <= (r_inflight & ~w_done_valid) | w_unit_start_nxt;
            r_outstanding <= r_outstanding + {3'd0, w_start_fire} - w_done_cnt;
            if (w_stray) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_data  = r_resp_data;
    assign unit_start = r_unit_start;
    assign unit_arg   = r_unit_arg;
    assign sched_idle = (r_state == S_IDLE) && (r_outstanding == 4'd0);
    assign err_sticky = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_npu_cmd_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for npu_cmd_scheduler: command table plus hand-written timing sequences;
// responses are checked against a queue of expected words.
module tb_npu_cmd_scheduler;

    localparam int NUM_UNITS      = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [31:0]          cmd_data;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [NUM_UNITS-1:0] unit_start;
    logic [23:0]          unit_arg;
    logic [NUM_UNITS-1:0] unit_busy;
    logic [NUM_UNITS-1:0] unit_done;
    logic [15:0]          resp_data;
    logic                 resp_valid;
    logic                 resp_ready;
    logic                 sched_idle;
    logic                 err_sticky;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    typedef struct packed {
        logic [31:0] cmd;
        logic        has_resp;
        logic [15:0] resp;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    npu_cmd_scheduler #(
        .NUM_UNITS      (NUM_UNITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .unit_start (unit_start),
        .unit_arg   (unit_arg),
        .unit_busy  (unit_busy),
        .unit_done  (unit_done),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .sched_idle (sched_idle),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] c);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready) fail_timeout("cmd_accept");
        cmd_data  = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(cmd_ready && exp_q.size() == 0) && n < 200) begin
            tick();
            n++;
        end
        if (!(cmd_ready && exp_q.size() == 0)) fail_timeout("wait_idle");
    endtask

    task automatic wait_start(input logic [NUM_UNITS-1:0] exp_mask, input logic [23:0] exp_arg);
        int n = 0;
        tick();
        while (unit_start == '0 && n < 50) begin
            tick();
            n++;
        end
        check("start_mask", 32'(unit_start), 32'(exp_mask));
        check("start_arg", 32'(unit_arg), 32'(exp_arg));
    endtask

    task automatic pulse_done(input logic [NUM_UNITS-1:0] d);
        unit_done = d;
        tick();
        unit_done = '0;
    endtask

    // Response handshakes are scored half a cycle before the accepting edge.
    always @(negedge clk) begin : resp_mon
        logic [15:0] e;
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_unexpected: got %h expected none", resp_data);
            end else begin
                e = exp_q.pop_front();
                check("resp_data", 32'(resp_data), 32'(e));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h4000_0000, 1'b1, 16'h4000};
        vecs[1] = '{32'h0000_0000, 1'b0, 16'h0000};
        vecs[2] = '{32'h9123_4567, 1'b1, 16'hF902};
        vecs[3] = '{32'h1000_0000, 1'b1, 16'hF102};
        vecs[4] = '{32'h2700_0000, 1'b1, 16'hF201};
        vecs[5] = '{32'h2400_0000, 1'b1, 16'hF201};
        vecs[6] = '{32'h4A00_0000, 1'b1, 16'h4A00};
        vecs[7] = '{32'h3C00_0000, 1'b1, 16'h3C00};
        vecs[8] = '{32'hF000_0000, 1'b1, 16'hFF02};

        rst        = 1'b1;
        cmd_data   = '0;
        cmd_valid  = 1'b0;
        unit_busy  = '0;
        unit_done  = '0;
        resp_ready = 1'b1;
        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_sched_idle", 32'(sched_idle), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_unit_start", 32'(unit_start), 32'd0);
        check("rst_unit_arg", 32'(unit_arg), 32'd0);
        check("rst_err_sticky", 32'(err_sticky), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].has_resp) exp_q.push_back(vecs[i].resp);
            send_cmd(vecs[i].cmd);
            wait_idle();
            check("vec_idle", 32'(sched_idle), 32'd1);
        end

        // START latency: accept edge, DECODE, DISPATCH, pulse visible.
        send_cmd(32'h2100_00AB);
        check("lat_decode", 32'(unit_start), 32'd0);
        tick();
        check("lat_dispatch", 32'(unit_start), 32'd0);
        tick();
        check("lat_start", 32'(unit_start), 32'b0010);
        check("lat_arg", 32'(unit_arg), 32'h0000AB);
        tick();
        check("lat_one_cycle", 32'(unit_start), 32'd0);
        exp_q.push_back(16'h4002);
        send_cmd(32'h4000_0000);
        wait_idle();
        check("busy_not_idle", 32'(sched_idle), 32'd0);
        pulse_done(4'b0010);
        check("done1_idle", 32'(sched_idle), 32'd1);

        // Two completions in one cycle.
        send_cmd(32'h2200_0001);
        wait_start(4'b0100, 24'h000001);
        send_cmd(32'h2300_0002);
        wait_start(4'b1000, 24'h000002);
        exp_q.push_back(16'h400C);
        send_cmd(32'h4000_0000);
        wait_idle();
        pulse_done(4'b1100);
        check("multi_done_idle", 32'(sched_idle), 32'd1);

        // Busy unit holds dispatch; start and done land on the same edge.
        send_cmd(32'h2100_0011);
        wait_start(4'b0010, 24'h000011);
        unit_busy = 4'b0001;
        send_cmd(32'h2000_0CDE);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("busy_hold", 32'(unit_start), 32'd0);
        end
        unit_busy = 4'b0000;
        unit_done = 4'b0010;
        tick();
        unit_done = '0;
        check("busy_release_start", 32'(unit_start), 32'b0001);
        check("busy_release_arg", 32'(unit_arg), 32'h000CDE);
        exp_q.push_back(16'h4001);
        send_cmd(32'h4000_0000);
        wait_idle();
        pulse_done(4'b0001);
        check("same_edge_idle", 32'(sched_idle), 32'd1);
        check("no_stray_yet", 32'(err_sticky), 32'd0);

        // Stray completion.
        pulse_done(4'b0001);
        check("stray_err", 32'(err_sticky), 32'd1);
        check("stray_idle", 32'(sched_idle), 32'd1);

        // SYNC waits for unit 2, then holds under backpressure.
        resp_ready = 1'b0;
        send_cmd(32'h2200_0000);
        wait_start(4'b0100, 24'h000000);
        send_cmd(32'h3500_0000);
        repeat (9) tick();
        check("sync_waiting", 32'(resp_valid), 32'd0);
        pulse_done(4'b0100);
        check("sync_not_yet", 32'(resp_valid), 32'd0);
        tick();
        check("sync_valid", 32'(resp_valid), 32'd1);
        check("sync_data", 32'(resp_data), 32'h3500);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_data", 32'(resp_data), 32'h3500);
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        exp_q.push_back(16'h3500);
        resp_ready = 1'b1;
        wait_idle();
        check("sync_done_idle", 32'(sched_idle), 32'd1);

`ifdef NPU_SCHED_TIMEOUT_EN
        send_cmd(32'h2000_0000);
        wait_start(4'b0001, 24'h000000);
        resp_ready = 1'b0;
        send_cmd(32'h3000_0000);
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("to_early", 32'(resp_valid), 32'd0);
            tick();
        end
        check("to_valid", 32'(resp_valid), 32'd1);
        check("to_data", 32'(resp_data), 32'hF303);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("to_rst_valid", 32'(resp_valid), 32'd0);
        check("to_rst_idle", 32'(sched_idle), 32'd1);
        resp_ready = 1'b1;
`endif

        // Reset while a response is pending.
        resp_ready = 1'b0;
        send_cmd(32'h4000_0000);
        tick();
        check("pend_valid", 32'(resp_valid), 32'd1);
        check("pend_data", 32'(resp_data), 32'h4000);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_data", 32'(resp_data), 32'd0);
        check("mid_rst_err", 32'(err_sticky), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_idle", 32'(sched_idle), 32'd1);
        rst = 1'b0;
        resp_ready = 1'b1;
        repeat (3) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
